// File: rtl/onn_phase_load_ctrl.sv
// rtl/onn_phase_load_ctrl.sv - load/run/capture sequencer for the ONN neuron array (optional PARITY_CHECK_EN)
module onn_phase_load_ctrl #(
  parameter int ROWS       = 5,
  parameter int COLS       = 3,
  parameter int PHW        = 4,
  parameter int RUN_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         ser_bit,
  input  logic                         ser_valid,
  input  logic [0:ROWS*COLS*PHW-1]     phi_array,
  output logic [0:ROWS*COLS*PHW-1]     phi_init,
  output logic                         load_en,
  output logic                         run_en,
  output logic [0:ROWS*COLS*PHW-1]     result,
  output logic                         busy,
  output logic                         done,
  output logic                         frame_err
);

  localparam int N   = ROWS * COLS * PHW;
  localparam int BCW = $clog2(N + 1);
  localparam int RCW = $clog2(RUN_CYCLES + 1);

  localparam logic [BCW-1:0] LAST_BIT = BCW'(N - 1);
  localparam logic [RCW-1:0] RUN_LAST = RCW'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t         state;
  logic [BCW-1:0] bit_cnt;
  logic [RCW-1:0] run_cnt;

`ifdef PARITY_CHECK_EN
  localparam logic [BCW-1:0] PAR_BIT = BCW'(N);
  logic par_acc;
`else
  assign frame_err = 1'b0;
`endif

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      run_cnt  <= '0;
      phi_init <= '0;
      result   <= '0;
      load_en  <= 1'b0;
      run_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_acc   <= 1'b0;
      frame_err <= 1'b0;
`endif
    end else begin
      load_en <= 1'b0;
      if (abort) begin
        // Abort wins over everything; captured data and loaded phases are kept.
        state  <= S_IDLE;
        run_en <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state   <= S_SHIFT;
              bit_cnt <= '0;
              busy    <= 1'b1;
              done    <= 1'b0;
`ifdef PARITY_CHECK_EN
              par_acc   <= 1'b0;
              frame_err <= 1'b0;
`endif
            end
          end
          S_SHIFT: begin
            if (ser_valid) begin
`ifdef PARITY_CHECK_EN
              if (bit_cnt == PAR_BIT) begin
                // Trailing even-parity bit decides whether the frame is loaded.
                if (par_acc ^ ser_bit) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                end else begin
                  state   <= S_LOAD;
                  load_en <= 1'b1;
                end
              end else begin
                phi_init[bit_cnt] <= ser_bit;
                par_acc           <= par_acc ^ ser_bit;
                bit_cnt           <= bit_cnt + 1'b1;
              end
`else
              phi_init[bit_cnt] <= ser_bit;
              bit_cnt           <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state   <= S_LOAD;
                load_en <= 1'b1;
              end
`endif
            end
          end
          S_LOAD: begin
            state   <= S_RUN;
            run_en  <= 1'b1;
            run_cnt <= '0;
          end
          S_RUN: begin
            if (run_cnt == RUN_LAST) begin
              state  <= S_CAPTURE;
              run_en <= 1'b0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end
          S_CAPTURE: begin
            result <= phi_array;
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
